// File: rtl/vip_pkt_pkg.sv
// Shared constants and types for the VIP packet parser: packet type codes,
// control-packet nibble lanes and the parser FSM state encoding.
package vip_pkt_pkg;

  localparam logic [3:0] PKT_VIDEO = 4'h0;
  localparam logic [3:0] PKT_CTRL  = 4'hF;

  // Bit offsets of the three control nibbles inside one 24-bit beat
  localparam int LANE0 = 0;
  localparam int LANE1 = 8;
  localparam int LANE2 = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_VIDEO   = 3'd1,
    ST_CTRL    = 3'd2,
    ST_DISCARD = 3'd3,
    ST_DROP    = 3'd4
  } state_t;

endpackage

// File: rtl/vip_skid_buffer.sv
// Two-entry in-order buffer between the parser and a ready-latency-0 source.
// Each entry holds {sop, eop, data}; a write and a pop may happen together.
module vip_skid_buffer #(
  parameter int W     = 26,
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         aclr,
  input  logic         wr,
  input  logic [W-1:0] wr_data,
  output logic         full,
  output logic [1:0]   occupancy,
  output logic [W-1:0] src_data,
  output logic         src_valid,
  input  logic         src_ready
);

  localparam logic [1:0] FULL_LVL = 2'(DEPTH);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         push;
  logic         pop;

  assign pop  = src_valid & src_ready;
  // When full, a same-cycle pop frees the slot the write lands in
  assign push = wr & (~full | pop);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      // NOTE: storage is reset so src_data reads 0 rather than X after aclr.
      mem[0]    <= '0;
      mem[1]    <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 2'd1;
        2'b01:   occupancy <= occupancy - 2'd1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  assign full      = (occupancy == FULL_LVL);
  assign src_valid = (occupancy != 2'd0);
  assign src_data  = mem[rd_ptr];

endmodule

// File: rtl/vip_packet_parser.sv
// Avalon-ST Video packet parser: decodes VIP headers, latches geometry from
// control packets and re-frames video pixels to the latched width x height.
module vip_packet_parser
  import vip_pkt_pkg::*;
#(
  parameter int DATA_W    = 24,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clock,
  input  logic              aclr,
  input  logic [DATA_W-1:0] sink_data,
  input  logic [1:0]        sink_empty,
  input  logic              sink_startofpacket,
  input  logic              sink_endofpacket,
  input  logic              sink_valid,
  output logic              sink_ready,
  output logic [DATA_W-1:0] src_data,
  output logic              src_startofpacket,
  output logic              src_endofpacket,
  output logic              src_valid,
  input  logic              src_ready,
  output logic [15:0]       frame_width,
  output logic [15:0]       frame_height,
  output logic [3:0]        interlace,
  output logic              ctrl_valid,
  output logic              frame_done,
  output logic              err_short,
  output logic              err_long,
  output logic [15:0]       frame_count
);

  state_t      state;
  logic [1:0]  ctrl_beat;
  logic [15:0] w_stage;
  logic [7:0]  h_stage;
  logic        ctrl_seen;
  logic [15:0] w_lat;
  logic [15:0] h_lat;
  logic [15:0] x;
  logic [15:0] y;
  logic        chk_en;
  logic        first_px;
  logic        drop_first;

  logic [1:0]  occupancy;
  logic        full;
  logic        wr;
  logic        wr_eop;
  logic        last_x;
  logic        last_y;
  logic        at_end;
  logic [3:0]  nib0;
  logic [3:0]  nib1;
  logic [3:0]  nib2;
  logic        unused_bits;

  assign unused_bits = ^{sink_empty, full};

  // A beat granted now can land next cycle, so count the one already in flight
  assign sink_ready = ~aclr & (({1'b0, occupancy} + {2'b00, sink_valid}) <= 3'd1);

  assign nib0   = sink_data[LANE0 +: 4];
  assign nib1   = sink_data[LANE1 +: 4];
  assign nib2   = sink_data[LANE2 +: 4];

  assign last_x = (x == w_lat - 16'd1);
  assign last_y = (y == h_lat - 16'd1);
  assign at_end = chk_en & last_x & last_y;
  assign wr     = (state == ST_VIDEO) & sink_valid;
  assign wr_eop = at_end | sink_endofpacket;

  vip_skid_buffer #(
    .W     (DATA_W + 2),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clock     (clock),
    .aclr      (aclr),
    .wr        (wr),
    .wr_data   ({first_px, wr_eop, sink_data}),
    .full      (full),
    .occupancy (occupancy),
    .src_data  ({src_startofpacket, src_endofpacket, src_data}),
    .src_valid (src_valid),
    .src_ready (src_ready)
  );

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state        <= ST_IDLE;
      ctrl_beat    <= 2'd0;
      w_stage      <= 16'd0;
      h_stage      <= 8'd0;
      ctrl_seen    <= 1'b0;
      w_lat        <= 16'd0;
      h_lat        <= 16'd0;
      x            <= 16'd0;
      y            <= 16'd0;
      chk_en       <= 1'b0;
      first_px     <= 1'b0;
      drop_first   <= 1'b0;
      frame_width  <= 16'd0;
      frame_height <= 16'd0;
      interlace    <= 4'd0;
      ctrl_valid   <= 1'b0;
      frame_done   <= 1'b0;
      err_short    <= 1'b0;
      err_long     <= 1'b0;
      frame_count  <= 16'd0;
    end else begin
      ctrl_valid <= 1'b0;
      frame_done <= 1'b0;
      err_short  <= 1'b0;
      err_long   <= 1'b0;
      if (sink_valid) begin
        case (state)
          ST_IDLE: begin
            // Header beats that also carry eop are complete packets on their own
            if (sink_startofpacket && !sink_endofpacket) begin
              if (sink_data[3:0] == PKT_VIDEO) begin
                state    <= ST_VIDEO;
                w_lat    <= frame_width;
                h_lat    <= frame_height;
                chk_en   <= ctrl_seen & (frame_width != 16'd0) & (frame_height != 16'd0);
                x        <= 16'd0;
                y        <= 16'd0;
                first_px <= 1'b1;
              end else if (sink_data[3:0] == PKT_CTRL) begin
                state     <= ST_CTRL;
                ctrl_beat <= 2'd0;
              end else begin
                state <= ST_DISCARD;
              end
            end
          end
          ST_CTRL: begin
            case (ctrl_beat)
              2'd0: w_stage[15:4] <= {nib0, nib1, nib2};
              2'd1: begin
                w_stage[3:0] <= nib0;
                h_stage      <= {nib1, nib2};
              end
              2'd2: begin
                frame_width  <= w_stage;
                frame_height <= {h_stage, nib0, nib1};
                interlace    <= nib2;
                ctrl_valid   <= 1'b1;
                ctrl_seen    <= 1'b1;
              end
              default: ;
            endcase
            if (ctrl_beat != 2'd3) ctrl_beat <= ctrl_beat + 2'd1;
            if (sink_endofpacket) state <= ST_IDLE;
          end
          ST_VIDEO: begin
            first_px <= 1'b0;
            if (at_end) begin
              frame_done  <= 1'b1;
              frame_count <= frame_count + 16'd1;
              drop_first  <= 1'b1;
              state       <= sink_endofpacket ? ST_IDLE : ST_DROP;
            end else if (sink_endofpacket) begin
              frame_done <= 1'b1;
              if (chk_en) err_short <= 1'b1;
              else        frame_count <= frame_count + 16'd1;
              state <= ST_IDLE;
            end else if (last_x) begin
              x <= 16'd0;
              y <= y + 16'd1;
            end else begin
              x <= x + 16'd1;
            end
          end
          ST_DROP: begin
            if (drop_first) err_long <= 1'b1;
            drop_first <= 1'b0;
            if (sink_endofpacket) state <= ST_IDLE;
          end
          ST_DISCARD: begin
            if (sink_endofpacket) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
